// File: rtl/led_seq_pkg.sv
// Shared types for the LED pattern sequencer: mode encoding, per-mode start value
// and the bounce direction encoding.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_BLINK  = 2'd0,
        MODE_CHASE  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_FILL   = 2'd3
    } mode_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Every mode starts with only LED0 lit, except FILL which starts dark.
    function automatic logic start_lsb(input mode_e m);
        return (m != MODE_FILL);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: free-running modulo-DIV counter that holds while en is low and
// flags the wrap edge with a combinational tick.
module tick_gen #(
    parameter int DIV = 50_000_000
) (
    input  logic CLOCK_50,
    input  logic RESET,
    input  logic en,
    output logic tick
);

    localparam int              CW   = $clog2(DIV);
    localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (en) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_pattern_seq.sv
// LED bank pattern sequencer: synchronises the board switches, and on every
// prescaler tick either loads a newly selected mode or advances the current pattern.
module led_pattern_seq
    import led_seq_pkg::*;
#(
    parameter int DIV  = 50_000_000,
    parameter int NLED = 8
) (
    input  logic            CLOCK_50,
    input  logic            RESET,
    input  logic [1:0]      SW,
    input  logic            PAUSE,
    output logic [NLED-1:0] LEDG,
    output logic            STEP
);

    localparam logic [NLED-1:0] PAT_RESET = {{(NLED-1){1'b0}}, 1'b1};

    logic [1:0]      sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
    logic            pause_meta_q, pause_meta_d, pause_sync_q, pause_sync_d;
    mode_e           mode_q, mode_d;
    logic            dir_q, dir_d;
    logic [NLED-1:0] pat_q, pat_d;
    logic            step_q, step_d;
    logic            tick;
    mode_e           sw_mode;

    tick_gen #(.DIV(DIV)) u_tick_gen (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .en       (~pause_sync_q),
        .tick     (tick)
    );

    assign sw_mode = mode_e'(sw_sync_q);

    always_comb begin
        sw_meta_d    = SW;
        sw_sync_d    = sw_meta_q;
        pause_meta_d = PAUSE;
        pause_sync_d = pause_meta_q;
        mode_d       = mode_q;
        dir_d        = dir_q;
        pat_d        = pat_q;
        step_d       = tick;
        if (tick) begin
            // A mode change takes the whole tick; the new pattern advances from the next one.
            if (sw_mode != mode_q) begin
                mode_d = sw_mode;
                pat_d  = {{(NLED-1){1'b0}}, start_lsb(sw_mode)};
                dir_d  = DIR_UP;
            end else begin
                case (mode_q)
                    MODE_BLINK: begin
                        pat_d      = '0;
                        pat_d[1:0] = {pat_q[0], pat_q[1]};
                    end
                    MODE_CHASE: pat_d = {pat_q[NLED-2:0], pat_q[NLED-1]};
                    MODE_BOUNCE: begin
                        // Reversing on the end bit itself keeps each end LED lit for one step only.
                        if (dir_q == DIR_UP) begin
                            if (pat_q[NLED-1]) begin
                                pat_d = pat_q >> 1;
                                dir_d = DIR_DOWN;
                            end else begin
                                pat_d = pat_q << 1;
                            end
                        end else begin
                            if (pat_q[0]) begin
                                pat_d = pat_q << 1;
                                dir_d = DIR_UP;
                            end else begin
                                pat_d = pat_q >> 1;
                            end
                        end
                    end
                    MODE_FILL: pat_d = (&pat_q) ? '0 : {pat_q[NLED-2:0], 1'b1};
                    default: pat_d = pat_q;
                endcase
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            sw_meta_q    <= '0;
            sw_sync_q    <= '0;
            pause_meta_q <= 1'b0;
            pause_sync_q <= 1'b0;
            mode_q       <= MODE_BLINK;
            dir_q        <= DIR_UP;
            pat_q        <= PAT_RESET;
            step_q       <= 1'b0;
        end else begin
            sw_meta_q    <= sw_meta_d;
            sw_sync_q    <= sw_sync_d;
            pause_meta_q <= pause_meta_d;
            pause_sync_q <= pause_sync_d;
            mode_q       <= mode_d;
            dir_q        <= dir_d;
            pat_q        <= pat_d;
            step_q       <= step_d;
        end
    end

    assign LEDG = pat_q;
    assign STEP = step_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Bench for led_pattern_seq (DIV=4, NLED=8): constant vector table, tick-sequence
// scoreboard, and a random run checked every cycle against a step-index model.
module tb_led_pattern_seq;

    localparam int DIV  = 4;
    localparam int NLED = 8;
    localparam int BOUNCE_PERIOD = 2 * (NLED - 1);

    logic            clk;
    logic            RESET;
    logic [1:0]      SW;
    logic            PAUSE;
    logic [NLED-1:0] LEDG;
    logic            STEP;

    int n_vec;
    int n_err;

    logic [NLED-1:0] exp_q[$];

    // Model state: sync pipelines, prescaler phase, current mode and steps taken in it.
    logic [1:0] m_sw_pipe[$];
    logic       m_pause_pipe[$];
    int         m_phase;
    int         m_mode;
    int         m_k;
    logic       m_step;

    typedef struct {
        logic [1:0]      sw;
        logic            pause;
        logic [NLED-1:0] led;
        logic            step;
    } vec_t;

    vec_t tbl[12];

    led_pattern_seq #(.DIV(DIV), .NLED(NLED)) dut (
        .CLOCK_50 (clk),
        .RESET    (RESET),
        .SW       (SW),
        .PAUSE    (PAUSE),
        .LEDG     (LEDG),
        .STEP     (STEP)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [NLED-1:0] model_led(input int mode, input int k);
        int pos;
        case (mode)
            0: return (k % 2 == 0) ? 8'h01 : 8'h02;
            1: return 8'h01 << (k % NLED);
            2: begin
                pos = k % BOUNCE_PERIOD;
                if (pos > NLED - 1) pos = BOUNCE_PERIOD - pos;
                return 8'h01 << pos;
            end
            default: return 8'((1 << (k % (NLED + 1))) - 1);
        endcase
    endfunction

    task automatic check(input string name, input logic [NLED-1:0] act, input logic [NLED-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_sw_pipe    = {2'b00, 2'b00};
        m_pause_pipe = {1'b0, 1'b0};
        m_phase      = 0;
        m_mode       = 0;
        m_k          = 0;
        m_step       = 1'b0;
    endtask

    // One clock: advance the model on the rising edge, compare on the falling edge.
    task automatic cycle();
        logic [1:0] sw_used;
        logic       pause_used;
        logic       tick;
        @(posedge clk);
        if (RESET) begin
            model_reset();
        end else begin
            sw_used    = m_sw_pipe.pop_front();
            m_sw_pipe.push_back(SW);
            pause_used = m_pause_pipe.pop_front();
            m_pause_pipe.push_back(PAUSE);
            tick = 1'b0;
            if (!pause_used) begin
                if (m_phase == DIV - 1) begin
                    tick    = 1'b1;
                    m_phase = 0;
                end else begin
                    m_phase++;
                end
            end
            if (tick) begin
                if (int'(sw_used) != m_mode) begin
                    m_mode = int'(sw_used);
                    m_k    = 0;
                end else begin
                    m_k++;
                end
            end
            m_step = tick;
        end
        @(negedge clk);
        check("model_led", LEDG, model_led(m_mode, m_k));
        check("model_step", {7'd0, STEP}, {7'd0, m_step});
    endtask

    task automatic do_reset(input logic [1:0] sw);
        SW    = sw;
        PAUSE = 1'b0;
        RESET = 1'b1;
        #1;
        check("reset_led_async", LEDG, 8'h01);
        check("reset_step", {7'd0, STEP}, 8'h00);
        model_reset();
        repeat (2) cycle();
        RESET = 1'b0;
    endtask

    // Pops exp_q once per STEP pulse, with a bounded wait per tick.
    task automatic expect_ticks();
        int budget;
        while (exp_q.size() > 0) begin
            budget = 0;
            do begin
                cycle();
                budget++;
            end while (!STEP && budget < 3 * DIV);
            if (STEP) begin
                check("tick_seq", LEDG, exp_q.pop_front());
            end else begin
                n_vec++;
                n_err++;
                $display("FAIL tick_timeout at %0t: no STEP within %0d cycles, %0d ticks outstanding",
                         $time, 3 * DIV, exp_q.size());
                exp_q.delete();
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        RESET = 1'b1;
        SW    = 2'b00;
        PAUSE = 1'b0;
        model_reset();

        for (int i = 0; i < 12; i++) begin
            tbl[i].sw    = 2'b00;
            tbl[i].pause = 1'b0;
            tbl[i].led   = (((i + 1) / DIV) % 2 == 1) ? 8'h02 : 8'h01;
            tbl[i].step  = ((i + 1) % DIV == 0);
        end

        @(negedge clk);

        // Blink from reset, edges 1..12 after release.
        do_reset(2'b00);
        for (int i = 0; i < 12; i++) begin
            SW    = tbl[i].sw;
            PAUSE = tbl[i].pause;
            cycle();
            check("tbl_led", LEDG, tbl[i].led);
            check("tbl_step", {7'd0, STEP}, {7'd0, tbl[i].step});
        end

        // Chase: mode load then a full rotation.
        do_reset(2'b01);
        exp_q = {8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
        expect_ticks();

        // Bounce: one full turn plus one step.
        do_reset(2'b10);
        exp_q = {8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
        expect_ticks();

        // Fill: load dark, fill up, wrap to dark.
        do_reset(2'b11);
        exp_q = {8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00};
        expect_ticks();

        // Pause raised with the counter at 2; the tick in the sync window still lands.
        do_reset(2'b00);
        repeat (2) cycle();
        PAUSE = 1'b1;
        repeat (2) cycle();
        check("pause_window_tick_led", LEDG, 8'h02);
        check("pause_window_tick_step", {7'd0, STEP}, 8'h01);
        for (int i = 0; i < 8; i++) begin
            cycle();
            check("paused_led", LEDG, 8'h02);
            check("paused_step", {7'd0, STEP}, 8'h00);
        end
        PAUSE = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("resume_led", LEDG, 8'h02);
            check("resume_step", {7'd0, STEP}, 8'h00);
        end
        cycle();
        check("resume_tick_led", LEDG, 8'h01);
        check("resume_tick_step", {7'd0, STEP}, 8'h01);

        // Reset mid-fill at 0x0F, then mode load on the first tick after release.
        do_reset(2'b11);
        exp_q = {8'h00, 8'h01, 8'h03, 8'h07, 8'h0F};
        expect_ticks();
        do_reset(2'b11);
        exp_q = {8'h00, 8'h01};
        expect_ticks();

        // Random switches and pause, checked every cycle by the model.
        do_reset(2'($urandom_range(0, 3)));
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) SW = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) PAUSE = ~PAUSE;
            if ($urandom_range(0, 499) == 0) do_reset(SW);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
